// File: rtl/image_window_ctrl.sv
// Four-line raster buffer that turns a pixel stream into 3x3 windows.
// One line set is read per READ pass; the write side fills the fourth line meanwhile.
module image_window_ctrl #(
  parameter int NBIT        = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_WIDTH = 512
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NBIT-1:0]      i_pixel_data,
  input  logic                 i_pixel_valid,
  output logic                 o_ready,
  output logic [9*NBIT-1:0]    o_window,
  output logic                 o_window_valid,
  output logic                 o_line_done
);

  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int FILL_W = $clog2(4 * IMAGE_WIDTH) + 1;

  localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(4 * IMAGE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_START   = FILL_W'(3 * IMAGE_WIDTH);
  localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0]  COL_WIN_LAST = COL_W'(IMAGE_WIDTH - 3);

  typedef enum logic {IDLE, READ} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d;
  logic [1:0]          wr_line_q, wr_line_d;
  logic [COL_W-1:0]    rd_col_q, rd_col_d;
  logic [1:0]          rd_line_q, rd_line_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [9*NBIT-1:0]   window_q, window_d;
  logic                window_vld_q, window_vld_d;
  logic                line_done_q, line_done_d;

  logic [NBIT-1:0]     line_mem [4][IMAGE_WIDTH];
  logic [9*NBIT-1:0]   win_rd;
  logic                wr_en;
  logic                rd_en;

  assign o_ready        = (fill_cnt_q != FILL_FULL);
  assign o_window       = window_q;
  assign o_window_valid = window_vld_q;
  assign o_line_done    = line_done_q;

  assign wr_en = i_pixel_valid && o_ready;
  assign rd_en = (state_q == READ);

  // Line stores carry no reset; contents are only meaningful once rewritten.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_mem[wr_line_q][wr_col_q] <= i_pixel_data;
    end
  end

  // Row r of the window comes from line rd_line+r; row 0 is the oldest line.
  always_comb begin
    logic [1:0]       win_line;
    logic [COL_W-1:0] win_col;
    win_rd   = '0;
    win_line = '0;
    win_col  = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        win_line = rd_line_q + 2'(r);
        win_col  = rd_col_q + COL_W'(k);
        win_rd[NBIT*(KERNEL_SIZE*r+k) +: NBIT] = line_mem[win_line][win_col];
      end
    end
  end

  always_comb begin
    wr_col_d     = wr_col_q;
    wr_line_d    = wr_line_q;
    rd_col_d     = rd_col_q;
    rd_line_d    = rd_line_q;
    fill_cnt_d   = fill_cnt_q;
    state_d      = state_q;
    window_d     = window_q;
    window_vld_d = 1'b0;
    line_done_d  = 1'b0;

    if (wr_en) begin
      wr_col_d = wr_col_q + 1'b1;
      if (wr_col_q == COL_LAST) begin
        wr_line_d = wr_line_q + 1'b1;
      end
    end

    case ({wr_en, rd_en})
      2'b10:   fill_cnt_d = fill_cnt_q + 1'b1;
      2'b01:   fill_cnt_d = fill_cnt_q - 1'b1;
      default: fill_cnt_d = fill_cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (fill_cnt_q >= FILL_START) begin
          state_d = READ;
        end
      end
      READ: begin
        rd_col_d = rd_col_q + 1'b1;
        if (rd_col_q <= COL_WIN_LAST) begin
          window_d     = win_rd;
          window_vld_d = 1'b1;
        end
        // The last two columns of a line have no full 3-wide neighbourhood.
        if (rd_col_q == COL_LAST) begin
          rd_line_d   = rd_line_q + 1'b1;
          line_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      wr_col_q     <= '0;
      wr_line_q    <= '0;
      rd_col_q     <= '0;
      rd_line_q    <= '0;
      fill_cnt_q   <= '0;
      window_q     <= '0;
      window_vld_q <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      wr_line_q    <= wr_line_d;
      rd_col_q     <= rd_col_d;
      rd_line_q    <= rd_line_d;
      fill_cnt_q   <= fill_cnt_d;
      window_q     <= window_d;
      window_vld_q <= window_vld_d;
      line_done_q  <= line_done_d;
    end
  end

endmodule
